clk_enable_gen: RTL and testbench
=================================

Name: clk_enable_gen

Overview:
- Parametrised multi-channel clock-enable generator built on numerically controlled oscillators (NCOs). Derives NUM_CH independent, runtime-programmable tick rates from one reference clock.
- Sits beside the PLL output domain. Supplies slow strobes (sample, display refresh, wheel-sensor timebase) without instantiating extra PLLs.
- Adds what a fixed PLL lacks: per-channel frequency and phase, run-time reprogramming, and per-channel lock indication.

Parameters:
- NUM_CH, 4, number of channels (1..16).
- ACC_W, 24, phase-accumulator width in bits.
- LOCK_CYCLES, 16, enabled cycles with stable config before locked asserts (1..255).
- INC_DEFAULT, 4294967, reset increment for all channels (about 12.8 MHz tick from 50 MHz).
- CH_W, max(1,clog2(NUM_CH)), derived channel-select width; not overridden.

Ports:
- refclk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- enable  in  NUM_CH  per-channel run enable.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config accept.
- cfg_ch  in  CH_W  target channel.
- cfg_inc  in  ACC_W  new increment.
- cfg_phase  in  ACC_W  new start phase.
- tick  out  NUM_CH  one-cycle strobe on accumulator carry.
- outclk  out  NUM_CH  accumulator MSB, approx 50% duty square wave.
- locked  out  NUM_CH  channel running with stable config.

Behaviour:
- **Reset** (rst_n low at a refclk edge):
  - acc=0, inc=INC_DEFAULT, phase=0, lock counters=0.
  - tick=0, outclk=0, locked=0, cfg_ready=0, FSM=INIT.
  - All inputs are ignored while rst_n is low.
  - Reset mid-operation discards any pending config.
- **Config FSM**:
  - INIT: cfg_ready=0; moves to IDLE after one cycle.
  - IDLE: cfg_ready=1; on cfg_valid&&cfg_ready, latch cfg_ch/cfg_inc/cfg_phase and go to APPLY.
  - APPLY: cfg_ready=0; write inc[ch]=cfg_inc, phase[ch]=cfg_phase, acc[ch]=cfg_phase, clear lock counter[ch]; tick[ch]=0 that cycle; return to IDLE.
  - Throughput: at most one config per 2 cycles.
  - cfg_ch>=NUM_CH: handshake completes normally, no channel state changes.
- **Channel datapath**, enable[i]=1 and channel not in APPLY:
  - {carry,acc_next} = acc+inc, modulo 2^ACC_W.
  - tick[i] <= carry; outclk[i] <= acc_next[ACC_W-1]. Registered outputs, 1-cycle latency.
  - Tick rate = f_refclk*inc/2^ACC_W.
- **Channel datapath**, enable[i]=0:
  - acc[i] <= phase[i]; tick/outclk/locked/lock counter cleared.
  - Re-enable restarts from the stored phase, so channels enabled in the same cycle keep their programmed phase offsets.
- **Lock**:
  - Counter increments each enabled cycle, saturating at LOCK_CYCLES.
  - locked[i]=1 when counter==LOCK_CYCLES and inc[i]!=0.
  - inc==0: no ticks, outclk constant, locked held 0.
  - APPLY on a locked channel drops locked the next cycle and restarts the count.
- **Simultaneous events**:
  - APPLY coincident with an enable rise: config wins; acc loads cfg_phase.
  - APPLY coincident with a carry on that channel: carry suppressed (tick=0).
- **Boundaries**:
  - inc=2^(ACC_W-1): tick every 2 cycles.
  - inc>=2^(ACC_W-1): outclk aliases; this is the documented limit.
  - Accumulator wrap is silent, modulo arithmetic only.

Test Plan:
- Reset: rst_n low 5 cycles with enable=all ones -> tick/outclk/locked=0, cfg_ready=0; after release cfg_ready=0 for cycle 1, =1 from cycle 2.
- Default rate: release reset, enable[0]=1 for 50000 cycles -> 12800±1 ticks on tick[0]; locked[0]=1 from enabled cycle 16 onward.
- Program ch1 inc=2^22, phase=0, then enable -> tick[1] exactly every 4 cycles; outclk[1] 2 high/2 low; locked[1] rises 16 cycles after enable.
- Phase: ch2 inc=2^21 phase 0, ch3 inc=2^21 phase 2^23, both enabled same cycle -> both tick every 8 cycles, ch3 ticks lead ch2 by 4 cycles.
- Reconfig running ch1 to inc=2^21 -> locked[1]=0 the cycle after APPLY, =1 16 cycles later, period becomes 8; cfg_ch=7 (NUM_CH=4) -> handshake completes, all channels unchanged.
- Reset mid-run: rst_n low 1 cycle during APPLY -> next cycle all outputs 0, inc back to INC_DEFAULT, pending config lost; inc=0 on ch0 -> no ticks, locked[0] stays 0.

Source files
------------

// File: rtl/clk_enable_gen.sv
`default_nettype none
// ============================================================================
//  Module      : clk_enable_gen
//  Description : Multi-channel NCO clock-enable generator. Each channel owns a
//                phase accumulator with programmable increment and start
//                phase, producing a carry strobe (tick), an MSB square wave
//                (outclk) and a lock flag once its configuration has been
//                stable for LOCK_CYCLES enabled cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_enable_gen #(
    parameter int   NUM_CH      = 4,
    parameter int   ACC_W       = 24,
    parameter int   LOCK_CYCLES = 16,
    parameter int   INC_DEFAULT = 4294967,
    localparam int  CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] enable,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic [ACC_W-1:0]  cfg_phase,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] outclk,
    output logic [NUM_CH-1:0] locked
);

    // Lock counter only needs to reach LOCK_CYCLES, then it saturates.
    localparam int                 c_CNT_W       = $clog2(LOCK_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_LOCK_MAX    = c_CNT_W'(LOCK_CYCLES);
    localparam logic [ACC_W-1:0]   c_INC_DEFAULT = ACC_W'(INC_DEFAULT);

    // Config FSM encoding.
    localparam logic [1:0] c_ST_INIT  = 2'd0;
    localparam logic [1:0] c_ST_IDLE  = 2'd1;
    localparam logic [1:0] c_ST_APPLY = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic             w_apply_active;
    logic             w_accept;

    logic [CH_W-1:0]  r_cfg_ch;
    logic [ACC_W-1:0] r_cfg_inc;
    logic [ACC_W-1:0] r_cfg_phase;

    assign w_accept = cfg_valid && cfg_ready;

    // FSM state register; reset always returns to INIT and drops any pending request.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            r_state <= c_ST_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: INIT lasts one cycle, APPLY always returns to IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_INIT:  w_state_next = c_ST_IDLE;
            c_ST_IDLE:  if (cfg_valid) w_state_next = c_ST_APPLY;
            c_ST_APPLY: w_state_next = c_ST_IDLE;
            default:    w_state_next = c_ST_INIT;
        endcase
    end

    // FSM outputs: ready only in IDLE, which limits throughput to one config per 2 cycles.
    always_comb begin
        cfg_ready      = (r_state == c_ST_IDLE);
        w_apply_active = (r_state == c_ST_APPLY);
    end

    // Capture the accepted request so APPLY works from stable copies.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            r_cfg_ch    <= '0;
            r_cfg_inc   <= '0;
            r_cfg_phase <= '0;
        end else if (w_accept) begin
            r_cfg_ch    <= cfg_ch;
            r_cfg_inc   <= cfg_inc;
            r_cfg_phase <= cfg_phase;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [ACC_W-1:0]   r_acc;
        logic [ACC_W-1:0]   r_inc;
        logic [ACC_W-1:0]   r_phase;
        logic [c_CNT_W-1:0] r_lock_cnt;
        logic               r_tick;
        logic               r_outclk;
        logic [ACC_W:0]     w_sum;
        logic               w_apply;

        // Extra top bit of the sum is the accumulator carry.
        assign w_sum   = {1'b0, r_acc} + {1'b0, r_inc};
        // Out-of-range channel numbers simply match no channel.
        assign w_apply = w_apply_active && (r_cfg_ch == CH_W'(i));

        // Channel accumulator: config load wins over enable, disable parks at stored phase.
        always_ff @(posedge refclk) begin
            if (!rst_n) begin
                r_acc      <= '0;
                r_inc      <= c_INC_DEFAULT;
                r_phase    <= '0;
                r_lock_cnt <= '0;
                r_tick     <= 1'b0;
                r_outclk   <= 1'b0;
            end else if (w_apply) begin
                r_inc      <= r_cfg_inc;
                r_phase    <= r_cfg_phase;
                r_acc      <= r_cfg_phase;
                r_lock_cnt <= '0;
                r_tick     <= 1'b0;
                r_outclk   <= enable[i] & r_cfg_phase[ACC_W-1];
            end else if (!enable[i]) begin
                r_acc      <= r_phase;
                r_lock_cnt <= '0;
                r_tick     <= 1'b0;
                r_outclk   <= 1'b0;
            end else begin
                r_acc    <= w_sum[ACC_W-1:0];
                r_tick   <= w_sum[ACC_W];
                r_outclk <= w_sum[ACC_W-1];
                if (r_lock_cnt != c_LOCK_MAX) begin
                    r_lock_cnt <= r_lock_cnt + c_CNT_W'(1);
                end
            end
        end

        assign tick[i]   = r_tick;
        assign outclk[i] = r_outclk;
        // A zero increment never produces ticks, so it is never reported as locked.
        assign locked[i] = (r_lock_cnt == c_LOCK_MAX) && (r_inc != '0);
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_enable_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_enable_gen
//  Description : Directed self-checking bench for clk_enable_gen. A second
//                3-channel instance exercises an out-of-range channel number.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_enable_gen;

    localparam int   ACC_W   = 24;
    localparam int   INC_DEF = 4294967;

    logic        refclk;
    logic        rst_n;
    logic [3:0]  enable;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [23:0] cfg_inc;
    logic [23:0] cfg_phase;
    logic [3:0]  tick;
    logic [3:0]  outclk;
    logic [3:0]  locked;

    logic [2:0]  enable3;
    logic        cfg3_valid;
    logic        cfg3_ready;
    logic [1:0]  cfg3_ch;
    logic [23:0] cfg3_inc;
    logic [23:0] cfg3_phase;
    logic [2:0]  tick3;
    logic [2:0]  outclk3;
    logic [2:0]  locked3;

    int          n_checks;
    int          n_fail;
    int          cnt;
    longint      exp_cnt;

    clk_enable_gen #(
        .NUM_CH(4), .ACC_W(ACC_W), .LOCK_CYCLES(16), .INC_DEFAULT(INC_DEF)
    ) u_dut (
        .refclk(refclk), .rst_n(rst_n), .enable(enable),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_inc(cfg_inc), .cfg_phase(cfg_phase),
        .tick(tick), .outclk(outclk), .locked(locked)
    );

    clk_enable_gen #(
        .NUM_CH(3), .ACC_W(ACC_W), .LOCK_CYCLES(16), .INC_DEFAULT(INC_DEF)
    ) u_dut3 (
        .refclk(refclk), .rst_n(rst_n), .enable(enable3),
        .cfg_valid(cfg3_valid), .cfg_ready(cfg3_ready), .cfg_ch(cfg3_ch),
        .cfg_inc(cfg3_inc), .cfg_phase(cfg3_phase),
        .tick(tick3), .outclk(outclk3), .locked(locked3)
    );

    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Handshake one config word into u_dut; returns after the APPLY edge.
    task automatic cfg_write(input logic [1:0] ch, input logic [23:0] inc, input logic [23:0] ph);
        int w;
        w = 0;
        while (cfg_ready !== 1'b1 && w < 10) begin
            @(negedge refclk);
            w++;
        end
        check("cfg_ready_wait", cfg_ready, 1'b1);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_inc   = inc;
        cfg_phase = ph;
        @(negedge refclk);
        cfg_valid = 1'b0;
        @(negedge refclk);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        enable     = 4'hF;
        cfg_valid  = 1'b0;
        cfg_ch     = '0;
        cfg_inc    = '0;
        cfg_phase  = '0;
        enable3    = 3'b111;
        cfg3_valid = 1'b0;
        cfg3_ch    = '0;
        cfg3_inc   = '0;
        cfg3_phase = '0;

        // Reset held 5 cycles with all channels enabled.
        repeat (5) @(negedge refclk);
        check("rst_tick",   tick,      4'h0);
        check("rst_outclk", outclk,    4'h0);
        check("rst_locked", locked,    4'h0);
        check("rst_ready",  cfg_ready, 1'b0);
        check("rst_tick3",  tick3,     3'h0);

        // Release; default increment on channel 0.
        rst_n  = 1'b1;
        enable = 4'b0001;
        check("ready_cycle1", cfg_ready, 1'b0);
        cnt = 0;
        for (int k = 1; k <= 2000; k++) begin
            @(negedge refclk);
            if (tick[0]) cnt++;
            if (k == 1)  check("ready_cycle2", cfg_ready, 1'b1);
            if (k == 15) check("lock0_k15", locked[0], 1'b0);
            if (k == 16) check("lock0_k16", locked[0], 1'b1);
            if (k == 16) check("lock3_k16", locked3, 3'b111);
        end
        exp_cnt = (longint'(2000) * longint'(INC_DEF)) >>> ACC_W;
        check("default_rate", cnt, exp_cnt);

        // Channel 1: inc=2^22 -> period 4, outclk 2 high / 2 low.
        cfg_write(2'd1, 24'h400000, 24'h000000);
        enable[1] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge refclk);
            check("ch1_tick",   tick[1],   (k % 4) == 0);
            check("ch1_outclk", outclk[1], (k % 4) >= 2);
            if (k == 15) check("ch1_lock_k15", locked[1], 1'b0);
            if (k == 16) check("ch1_lock_k16", locked[1], 1'b1);
        end

        // Channels 2 and 3 with a half-period phase offset.
        cfg_write(2'd2, 24'h200000, 24'h000000);
        cfg_write(2'd3, 24'h200000, 24'h800000);
        enable[3:2] = 2'b11;
        for (int k = 1; k <= 16; k++) begin
            @(negedge refclk);
            check("ch2_tick", tick[2], (k % 8) == 0);
            check("ch3_tick", tick[3], (k % 8) == 4);
        end
        check("ch2_locked_run", locked[2], 1'b1);

        // Disable clears channel 2 outputs on the next edge.
        enable[2] = 1'b0;
        @(negedge refclk);
        check("ch2_dis_tick",   tick[2],   1'b0);
        check("ch2_dis_outclk", outclk[2], 1'b0);
        check("ch2_dis_locked", locked[2], 1'b0);

        // Boundary inc=2^23: tick every second cycle.
        cfg_write(2'd2, 24'h800000, 24'h000000);
        enable[2] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge refclk);
            check("ch2_half_tick",   tick[2],   (k % 2) == 0);
            check("ch2_half_outclk", outclk[2], (k % 2) == 1);
        end

        // Reconfigure running channel 1 to period 8.
        check("ch1_locked_pre", locked[1], 1'b1);
        cfg_write(2'd1, 24'h200000, 24'h000000);
        check("ch1_recfg_locked", locked[1], 1'b0);
        check("ch1_recfg_tick",   tick[1],   1'b0);
        for (int k = 1; k <= 16; k++) begin
            @(negedge refclk);
            check("ch1_p8_tick", tick[1], (k % 8) == 0);
            if (k == 15) check("ch1_relock_k15", locked[1], 1'b0);
            if (k == 16) check("ch1_relock_k16", locked[1], 1'b1);
        end

        // Out-of-range channel on the 3-channel instance.
        check("d3_locked_pre", locked3,    3'b111);
        check("d3_ready_pre",  cfg3_ready, 1'b1);
        cfg3_valid = 1'b1;
        cfg3_ch    = 2'd3;
        cfg3_inc   = 24'h800000;
        cfg3_phase = 24'h000005;
        @(negedge refclk);
        cfg3_valid = 1'b0;
        check("d3_ready_apply", cfg3_ready, 1'b0);
        @(negedge refclk);
        check("d3_ready_post",  cfg3_ready, 1'b1);
        check("d3_locked_post", locked3,    3'b111);
        @(negedge refclk);
        check("d3_locked_post2", locked3,   3'b111);

        // Reset asserted during APPLY discards the pending config.
        while (cfg_ready !== 1'b1) @(negedge refclk);
        cfg_valid = 1'b1;
        cfg_ch    = 2'd0;
        cfg_inc   = 24'h000000;
        cfg_phase = 24'h123456;
        @(negedge refclk);
        cfg_valid = 1'b0;
        rst_n     = 1'b0;
        @(negedge refclk);
        check("mid_rst_tick",   tick,      4'h0);
        check("mid_rst_outclk", outclk,    4'h0);
        check("mid_rst_locked", locked,    4'h0);
        check("mid_rst_ready",  cfg_ready, 1'b0);
        rst_n  = 1'b1;
        enable = 4'b0001;
        cnt    = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge refclk);
            if (tick[0]) cnt++;
            if (k == 16) check("post_rst_lock0", locked[0], 1'b1);
        end
        exp_cnt = (longint'(20) * longint'(INC_DEF)) >>> ACC_W;
        check("post_rst_rate", cnt, exp_cnt);

        // Zero increment: no ticks, no lock.
        cfg_write(2'd0, 24'h000000, 24'h000000);
        cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge refclk);
            if (tick[0]) cnt++;
        end
        check("inc0_ticks",  cnt,       0);
        check("inc0_locked", locked[0], 1'b0);
        check("inc0_outclk", outclk[0], 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
